wb_arb_stage: RTL and testbench
===============================

WB_ARB_STAGE -- requirements
Module: wb_arb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter REG_AW, default 5, register-address width.
REQ-003 SHALL have parameter LQ_DEPTH, default 4, long-latency queue entries (power of two, >=2).
REQ-004 SHALL have parameter STARVE_MAX, default 8, cycles a queued result waits before forcing a stall.
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port arst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port in_valid  input  1  main-pipe instruction present.
REQ-008 SHALL have ports in_opr_res, in_lsu_rdata, in_pc4, in_csr_rdata  input  XLEN each  candidate write data.
REQ-009 SHALL have port in_rd  input  REG_AW  destination register.
REQ-010 SHALL have port in_rf_en  input  1  instruction writes RF.
REQ-011 SHALL have port in_wb_sel  input  2  source select: 0 opr_res, 1 lsu_rdata, 2 pc4, 3 csr_rdata.
REQ-012 SHALL have port flush  input  1  kill main-pipe instruction being captured.
REQ-013 SHALL have ports ll_valid (input, 1), ll_data (input, XLEN), ll_rd (input, REG_AW)  long-latency (mul/div) result.
REQ-014 SHALL have port ll_ready  output  1  queue accepts a long-latency result.
REQ-015 SHALL have port stall  output  1  upstream must hold main-pipe inputs this cycle.
REQ-016 SHALL have ports rf_we (output, 1), rf_waddr (output, REG_AW), rf_wdata (output, XLEN)  single RF write port.

Function
REQ-017 SHALL capture main-pipe inputs into a stage register each cycle stall=0; selected data latched per in_wb_sel.
REQ-018 SHALL hold the stage register unchanged while stall=1.
REQ-019 SHALL set stage-register valid to 0 when flush=1 and stall=0, regardless of in_valid.
REQ-020 SHALL enqueue {ll_rd, ll_data} when ll_valid=1 and ll_ready=1; ll_ready = queue not full (no same-cycle enqueue-on-dequeue when full).
REQ-021 SHALL drive main write (stage valid & rf_en) on the RF port with priority; latency in_valid to rf_we = 1 cycle.
REQ-022 SHALL dequeue and write the queue head when no main write occurs and queue non-empty.
REQ-023 SHALL count consecutive cycles the queue is non-empty with the head not written; reset count on dequeue or empty.
REQ-024 SHALL assert stall (combinational from count) when count = STARVE_MAX; in that cycle the head is written, the stage register's main write is suppressed and retained for the next cycle.
REQ-025 SHALL suppress rf_we for any write with address 0; such a queue head still dequeues.
REQ-026 SHALL preserve FIFO order of long-latency results; wrap-around pointers modulo LQ_DEPTH.
REQ-027 SHALL NOT clear the queue on flush.
REQ-028 SHALL drive rf_waddr/rf_wdata to 0 when rf_we=0.

Reset
REQ-029 SHALL, on arst_n low, immediately clear stage valid, queue pointers, count; rf_we=0, stall=0, ll_ready=1.
REQ-030 SHALL discard queued results when reset asserts mid-operation; first write after release requires new input.

Verification
REQ-031 in_valid=1, in_rf_en=1, in_rd=5, in_wb_sel=2, in_pc4=0x104 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x104.
REQ-032 ll_valid with rd=3 data=0x2A while main pipe idle -> queued, written on a later cycle with rf_waddr=3, rf_wdata=0x2A.
REQ-033 Five ll results with LQ_DEPTH=4 and main pipe writing every cycle -> ll_ready=0 after 4th; results later written in issue order.
REQ-034 Main pipe writes every cycle, one queued entry -> stall=1 exactly when wait count reaches 8; queued entry written, held main write issued next cycle.
REQ-035 in_valid=1 with flush=1 -> no write; in_rd=0 with in_rf_en=1 -> rf_we stays 0.
REQ-036 arst_n pulsed low with 3 queued entries -> ll_ready=1, rf_we=0, no queued entry ever written.

Source files
------------

// File: rtl/wb_arb_stage.sv
// ---------------------------------------------------------------------------
// wb_arb_stage
//
// Write-back arbitration stage. Main-pipe results are captured into a single
// stage register and written to the register file one cycle later.
// Long-latency (mul/div) results are parked in a small FIFO and written
// whenever the main pipe leaves the RF write port free. If the FIFO head
// waits STARVE_MAX consecutive cycles, the stage stalls upstream for one
// cycle. In that cycle the head takes the port and the pending main write is
// held in the stage register.
//
// Ports
//   clk, arst_n          clock, asynchronous active-low reset
//   in_valid             main-pipe instruction present
//   in_opr_res ..        candidate write data (selected by in_wb_sel)
//   in_rd, in_rf_en      destination register, instruction writes RF
//   in_wb_sel            0 opr_res, 1 lsu_rdata, 2 pc4, 3 csr_rdata
//   flush                kill the main-pipe instruction being captured
//   ll_valid/data/rd     long-latency result offered to the queue
//   ll_ready             queue can accept a long-latency result
//   stall                upstream must hold main-pipe inputs this cycle
//   rf_we/waddr/wdata    single register-file write port (zeros when idle)
// ---------------------------------------------------------------------------
module wb_arb_stage #(
    parameter int XLEN       = 32,
    parameter int REG_AW     = 5,
    parameter int LQ_DEPTH   = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              in_valid,
    input  logic [XLEN-1:0]   in_opr_res,
    input  logic [XLEN-1:0]   in_lsu_rdata,
    input  logic [XLEN-1:0]   in_pc4,
    input  logic [XLEN-1:0]   in_csr_rdata,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_rf_en,
    input  logic [1:0]        in_wb_sel,
    input  logic              flush,
    input  logic              ll_valid,
    input  logic [XLEN-1:0]   ll_data,
    input  logic [REG_AW-1:0] ll_rd,
    output logic              ll_ready,
    output logic              stall,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata
);

    localparam int PTR_W = $clog2(LQ_DEPTH);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    // Stage register
    logic              r_valid;
    logic              r_rf_en;
    logic [REG_AW-1:0] r_rd;
    logic [XLEN-1:0]   r_data;

    // Long-latency queue. Pointers carry one extra wrap bit so full and
    // empty can be told apart when the index bits match.
    logic [XLEN-1:0]   r_lq_data [LQ_DEPTH];
    logic [REG_AW-1:0] r_lq_rd   [LQ_DEPTH];
    logic [PTR_W:0]    r_wr_ptr;
    logic [PTR_W:0]    r_rd_ptr;

    // Consecutive cycles the queue head has waited without being written
    logic [CNT_W-1:0]  r_starve;

    logic              w_empty;
    logic              w_full;
    logic              w_enq;
    logic              w_deq;
    logic              w_stall;
    logic              w_main_wr;
    logic [XLEN-1:0]   w_sel_data;
    logic [XLEN-1:0]   w_head_data;
    logic [REG_AW-1:0] w_head_rd;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]) &&
                       (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]);
    assign w_enq     = ll_valid & ~w_full;
    assign w_stall   = (r_starve == CNT_W'(STARVE_MAX));
    assign w_main_wr = r_valid & r_rf_en;
    // The head owns the port when the main pipe leaves it free, or
    // unconditionally when it has starved long enough to force a stall.
    assign w_deq     = ~w_empty & (w_stall | ~w_main_wr);

    assign w_head_data = r_lq_data[r_rd_ptr[PTR_W-1:0]];
    assign w_head_rd   = r_lq_rd[r_rd_ptr[PTR_W-1:0]];

    assign ll_ready = ~w_full;
    assign stall    = w_stall;

    always_comb begin
        w_sel_data = in_opr_res;
        case (in_wb_sel)
            2'd0:    w_sel_data = in_opr_res;
            2'd1:    w_sel_data = in_lsu_rdata;
            2'd2:    w_sel_data = in_pc4;
            default: w_sel_data = in_csr_rdata;
        endcase
    end

    // RF port. Writes to x0 are dropped; a queue head aimed at x0 still
    // dequeues because w_deq does not look at the address.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (w_deq) begin
            if (w_head_rd != '0) begin
                rf_we    = 1'b1;
                rf_waddr = w_head_rd;
                rf_wdata = w_head_data;
            end
        end else if (w_main_wr && (r_rd != '0)) begin
            rf_we    = 1'b1;
            rf_waddr = r_rd;
            rf_wdata = r_data;
        end
    end

    // Stage register: the stall cycle holds it, so the suppressed main
    // write is issued on the following cycle.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_valid <= 1'b0;
            r_rf_en <= 1'b0;
            r_rd    <= '0;
            r_data  <= '0;
        end else if (!w_stall) begin
            r_valid <= in_valid & ~flush;
            r_rf_en <= in_rf_en;
            r_rd    <= in_rd;
            r_data  <= w_sel_data;
        end
    end

    // Queue storage. It needs no reset because the pointers define
    // which entries are live.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_lq_data[r_wr_ptr[PTR_W-1:0]] <= ll_data;
            r_lq_rd[r_wr_ptr[PTR_W-1:0]]   <= ll_rd;
        end
    end

    // Queue pointers and the starvation counter. Flush does not touch
    // the queue.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_starve <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
            end
            if (w_empty || w_deq) begin
                r_starve <= '0;
            end else if (!w_stall) begin
                r_starve <= r_starve + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_arb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_arb_stage
//
// Directed test of wb_arb_stage with its default parameters. Inputs change
// 1 ns after each rising edge. Outputs depend only on registered state, so
// they are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_wb_arb_stage;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        in_valid;
    logic [31:0] in_opr_res, in_lsu_rdata, in_pc4, in_csr_rdata;
    logic [4:0]  in_rd;
    logic        in_rf_en;
    logic [1:0]  in_wb_sel;
    logic        flush;
    logic        ll_valid;
    logic [31:0] ll_data;
    logic [4:0]  ll_rd;
    logic        ll_ready, stall, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    wb_arb_stage dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .in_valid     (in_valid),
        .in_opr_res   (in_opr_res),
        .in_lsu_rdata (in_lsu_rdata),
        .in_pc4       (in_pc4),
        .in_csr_rdata (in_csr_rdata),
        .in_rd        (in_rd),
        .in_rf_en     (in_rf_en),
        .in_wb_sel    (in_wb_sel),
        .flush        (flush),
        .ll_valid     (ll_valid),
        .ll_data      (ll_data),
        .ll_rd        (ll_rd),
        .ll_ready     (ll_ready),
        .stall        (stall),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid     = 1'b0;
        in_opr_res   = '0;
        in_lsu_rdata = '0;
        in_pc4       = '0;
        in_csr_rdata = '0;
        in_rd        = '0;
        in_rf_en     = 1'b0;
        in_wb_sel    = '0;
        flush        = 1'b0;
        ll_valid     = 1'b0;
        ll_data      = '0;
        ll_rd        = '0;
    endtask

    logic [31:0] sel_exp [4];
    logic [4:0]  got_rd   [$];
    logic [31:0] got_data [$];
    int          k;
    int          first_stall;
    int          stale_writes;
    logic        acc;
    logic        full_checked;

    initial begin
        idle_inputs();
        arst_n = 1'b0;
        repeat (2) step();

        // Reset state
        check_eq("rst_rf_we", rf_we, 0);
        check_eq("rst_stall", stall, 0);
        check_eq("rst_ll_ready", ll_ready, 1);
        check_eq("rst_rf_waddr", rf_waddr, 0);
        arst_n = 1'b1;
        step();

        // Main write via pc4, one-cycle latency
        in_valid = 1'b1; in_rf_en = 1'b1; in_rd = 5; in_wb_sel = 2'd2;
        in_opr_res = 32'h11; in_lsu_rdata = 32'h22; in_pc4 = 32'h104; in_csr_rdata = 32'h33;
        step();
        in_valid = 1'b0;
        check_eq("pc4_rf_we", rf_we, 1);
        check_eq("pc4_rf_waddr", rf_waddr, 5);
        check_eq("pc4_rf_wdata", rf_wdata, 32'h104);

        // Every write-back source
        sel_exp = '{32'h11, 32'h22, 32'h104, 32'h33};
        for (int s = 0; s < 4; s++) begin
            in_valid = 1'b1; in_wb_sel = 2'(s); in_rd = 5'(6 + s);
            step();
            check_eq($sformatf("sel%0d_wdata", s), rf_wdata, sel_exp[s]);
            check_eq($sformatf("sel%0d_waddr", s), rf_waddr, 6 + s);
        end
        in_valid = 1'b0;
        step();
        check_eq("idle_rf_we", rf_we, 0);

        // Long-latency result while the main pipe is idle
        ll_valid = 1'b1; ll_rd = 3; ll_data = 32'h2A;
        step();
        ll_valid = 1'b0;
        check_eq("ll_rf_we", rf_we, 1);
        check_eq("ll_rf_waddr", rf_waddr, 3);
        check_eq("ll_rf_wdata", rf_wdata, 32'h2A);
        step();
        check_eq("ll_drained_rf_we", rf_we, 0);

        // Flushed instruction and an x0 destination never write
        in_valid = 1'b1; in_rf_en = 1'b1; in_rd = 7; in_wb_sel = 2'd0; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check_eq("flush_rf_we", rf_we, 0);
        in_valid = 1'b1; in_rd = 0; in_opr_res = 32'h55;
        step();
        in_valid = 1'b0;
        check_eq("x0_rf_we", rf_we, 0);
        check_eq("x0_rf_wdata", rf_wdata, 0);
        step();

        // Five long-latency results against a busy main pipe: queue fills
        // after four, and all five come out in issue order.
        in_valid = 1'b1; in_rf_en = 1'b1; in_rd = 10; in_wb_sel = 2'd0; in_opr_res = 32'hAAA;
        k = 0;
        full_checked = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc == 20) in_valid = 1'b0;
            ll_valid = (k < 5);
            ll_rd    = 5'(20 + k);
            ll_data  = 32'h100 + 32'(k);
            acc      = ll_valid && ll_ready;
            step();
            if (acc) k++;
            if (k == 4 && !full_checked) begin
                check_eq("lq_ready_after_4", ll_ready, 0);
                full_checked = 1'b1;
            end
            if (rf_we && rf_waddr >= 20) begin
                got_rd.push_back(rf_waddr);
                got_data.push_back(rf_wdata);
            end
        end
        ll_valid = 1'b0;
        check_eq("lq_all_accepted", k, 5);
        check_eq("lq_write_count", got_rd.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < got_rd.size()) begin
                check_eq($sformatf("lq_order%0d_rd", i), got_rd[i], 20 + i);
                check_eq($sformatf("lq_order%0d_data", i), got_data[i], 32'h100 + i);
            end
        end
        idle_inputs();
        repeat (4) step();

        // Starvation: one queued entry behind a main write every cycle
        in_valid = 1'b1; in_rf_en = 1'b1; in_rd = 9; in_wb_sel = 2'd0;
        first_stall = -1;
        for (int i = 1; i <= 12; i++) begin
            // Change the inputs during the stall to show the stage holds.
            in_opr_res = stall ? 32'hDEAD : 32'h500 + 32'(i);
            ll_valid = (i == 1); ll_rd = 4; ll_data = 32'h77;
            step();
            if (stall && first_stall < 0) begin
                first_stall = i;
                check_eq("starve_head_we", rf_we, 1);
                check_eq("starve_head_addr", rf_waddr, 4);
                check_eq("starve_head_data", rf_wdata, 32'h77);
            end
            if (i == 8) begin
                check_eq("starve_main_prio_addr", rf_waddr, 9);
                check_eq("starve_main_prio_data", rf_wdata, 32'h508);
            end
            if (i == 10) begin
                check_eq("starve_held_stall", stall, 0);
                check_eq("starve_held_addr", rf_waddr, 9);
                check_eq("starve_held_data", rf_wdata, 32'h509);
            end
        end
        check_eq("starve_first_cycle", first_stall, 9);
        idle_inputs();
        repeat (4) step();

        // Reset with three entries queued discards them
        in_valid = 1'b1; in_rf_en = 1'b1; in_rd = 1; in_opr_res = 32'h9;
        for (int j = 0; j < 3; j++) begin
            ll_valid = 1'b1; ll_rd = 5'(11 + j); ll_data = 32'hB1 + 32'(j);
            step();
        end
        idle_inputs();
        #2 arst_n = 1'b0;
        #1;
        check_eq("arst_rf_we", rf_we, 0);
        check_eq("arst_ll_ready", ll_ready, 1);
        check_eq("arst_stall", stall, 0);
        repeat (2) step();
        arst_n = 1'b1;
        stale_writes = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (rf_we) stale_writes++;
        end
        check_eq("arst_no_stale_writes", stale_writes, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
